// File: rtl/mcp_pipe_reg.sv
// mcp_pipe_reg: DEPTH-stage stallable pipeline register chain with valid/ready
// handshakes at both ends, bubble collapsing, global enable, flush and a
// registered occupancy count.

// One register stage: data word plus valid bit.
module mcp_pipe_stage #(
    parameter int WL       = 32,
    parameter int CLR_DATA = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr_i,      // flush: drop valid (and data if CLR_DATA)
    input  logic          ld_i,       // stage takes d_i/v_i this edge
    input  logic [WL-1:0] d_i,
    input  logic          v_i,
    output logic [WL-1:0] data_o,
    output logic          valid_o,
    output logic          valid_nxt_o // next valid, excluding reset
);

    logic [WL-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    // Next-state for valid and data; flush wins over a load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            if (CLR_DATA != 0) data_d = '0;
        end else if (ld_i) begin
            valid_d = v_i;
            data_d  = d_i;
        end
    end

    // Valid register; reset always clears it.
    always_ff @(posedge CLK) begin
        if (RST) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Data register; reset zeroes it only when CLR_DATA is set, otherwise holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (CLR_DATA != 0) data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;

endmodule

// Chain top: backward readiness, stage array and occupancy counter.
module mcp_pipe_reg #(
    parameter int WL       = 32,
    parameter int DEPTH    = 2,
    parameter int CLR_DATA = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         FLUSH,
    input  logic [WL-1:0]                pipe_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WL-1:0]                pipe_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WL-1:0] data_q;
    logic [DEPTH-1:0][WL-1:0] stg_d;
    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         valid_d;
    logic [DEPTH-1:0]         stg_v;
    logic [DEPTH-1:0]         ld;
    logic [DEPTH:0]           rdy;
    logic                     adv;
    logic                     flush_act;
    logic                     xfer_in;
    logic [OCC_W-1:0]         occ_q, occ_d;

    // Flush and advance only act while enabled; EN=0 freezes everything.
    assign adv       = EN && !FLUSH;
    assign flush_act = EN && FLUSH;

    // Readiness ripples backward: a stage can take new content if it is
    // empty or its own content moves on this edge.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            rdy[i] = !valid_q[i] || rdy[i+1];
    end

    assign in_ready = adv && rdy[0];
    assign xfer_in  = in_valid && in_ready;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stg
            // A stage loads from its predecessor whenever it can accept;
            // empty slots thus fill behind a stalled last stage.
            assign ld[g] = adv && rdy[g];
            if (g == 0) begin : g_head
                assign stg_d[g] = pipe_in;
                assign stg_v[g] = xfer_in;
            end else begin : g_body
                assign stg_d[g] = data_q[g-1];
                assign stg_v[g] = valid_q[g-1];
            end
            mcp_pipe_stage #(.WL(WL), .CLR_DATA(CLR_DATA)) u_stg (
                .CLK        (CLK),
                .RST        (RST),
                .clr_i      (flush_act),
                .ld_i       (ld[g]),
                .d_i        (stg_d[g]),
                .v_i        (stg_v[g]),
                .data_o     (data_q[g]),
                .valid_o    (valid_q[g]),
                .valid_nxt_o(valid_d[g])
            );
        end
    endgenerate

    // Occupancy is the population count of the next valid vector.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_d = occ_d + OCC_W'(valid_d[i]);
    end

    // Registered occupancy, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign out_valid = EN && valid_q[DEPTH-1];
    assign pipe_out  = data_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule
